// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// The write-control encoding matches the memory stage.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam logic [1:0] WC_BYTE = 2'b00;
    localparam logic [1:0] WC_HALF = 2'b01;
    localparam logic [1:0] WC_WORD = 2'b10;

    localparam int TIMER_W  = 8;
    localparam int STREAK_W = 4;

    // A data grant while a fetch is waiting extends the streak; otherwise the streak restarts.
    function automatic logic [STREAK_W-1:0] streakAfterDataGrant(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] maxStreak,
        input logic                fetchPending
    );
        logic [STREAK_W-1:0] result;
        result = '0;
        if (fetchPending) begin
            result = (cur == maxStreak) ? cur : cur + STREAK_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Memory-side wait counter: loads on grant, counts wait cycles,
// and flags expiry on the last allowed wait cycle.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_loadValue,
    input  logic               i_enable,
    output logic               o_expired
);

    logic [TIMER_W-1:0] r_count;
    logic               w_expired;

    assign w_expired = (r_count == TIMER_W'(TIMEOUT - 1));
    assign o_expired = w_expired;

    // Holds at the expiry value rather than wrapping, so a late enable cannot re-arm it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_enable && !w_expired) begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one variable-latency memory,
// with a fetch-starvation guard and a per-access memory timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wd,
    input  logic [1:0]        d_wc,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wd,
    output logic [1:0]        m_wc,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t r_state;
    arb_state_t w_nextState;
    arb_owner_t r_owner;

    logic [STREAK_W-1:0] r_streak;
    logic                w_streakFull;

    logic                w_grantI;
    logic                w_grantD;
    logic                w_done;
    logic                w_busy;
    logic                w_expired;
    logic [DATA_W-1:0]   w_respData;
    logic                w_respErr;

    logic              r_mReq;
    logic              r_mWe;
    logic [ADDR_W-1:0] r_mAddr;
    logic [DATA_W-1:0] r_mWd;
    logic [1:0]        r_mWc;
    logic [DATA_W-1:0] r_iRdata;
    logic              r_iReady;
    logic              r_iErr;
    logic [DATA_W-1:0] r_dRdata;
    logic              r_dReady;
    logic              r_dErr;

    assign w_streakFull = (r_streak == STREAK_W'(MAX_D_STREAK));
    assign w_busy       = (r_state == BUSY_I) || (r_state == BUSY_D);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK         (CLK),
        .reset       (reset),
        .i_clear     (r_state == RESP),
        .i_load      (w_grantI || w_grantD),
        .i_loadValue ('0),
        .i_enable    (w_busy && !m_ack),
        .o_expired   (w_expired)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Data normally wins a tie; a full streak hands the next grant to the waiting fetch.
    always_comb begin
        w_nextState = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && !(i_req && w_streakFull)) begin
                    w_nextState = BUSY_D;
                    w_grantD    = 1'b1;
                end else if (i_req) begin
                    w_nextState = BUSY_I;
                    w_grantI    = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ack || w_expired) begin
                    w_nextState = RESP;
                    w_done      = 1'b1;
                end
            end
            RESP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // An ack arriving on the expiry cycle still counts as a successful access.
    always_comb begin
        w_respData = '0;
        w_respErr  = 1'b1;
        if (m_ack) begin
            w_respErr  = 1'b0;
            w_respData = r_mWe ? '0 : m_rdata;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_owner  <= OWN_I;
            r_streak <= '0;
            r_mReq   <= 1'b0;
            r_mWe    <= 1'b0;
            r_mAddr  <= '0;
            r_mWd    <= '0;
            r_mWc    <= WC_BYTE;
            r_iRdata <= '0;
            r_iReady <= 1'b0;
            r_iErr   <= 1'b0;
            r_dRdata <= '0;
            r_dReady <= 1'b0;
            r_dErr   <= 1'b0;
        end else begin
            r_iReady <= 1'b0;
            r_dReady <= 1'b0;
            if (w_grantD) begin
                r_owner  <= OWN_D;
                r_mReq   <= 1'b1;
                r_mWe    <= d_we;
                r_mAddr  <= d_addr;
                r_mWd    <= d_wd;
                r_mWc    <= d_wc;
                r_streak <= streakAfterDataGrant(r_streak, STREAK_W'(MAX_D_STREAK), i_req);
            end else if (w_grantI) begin
                r_owner  <= OWN_I;
                r_mReq   <= 1'b1;
                r_mWe    <= 1'b0;
                r_mAddr  <= i_addr;
                r_mWd    <= '0;
                r_mWc    <= WC_WORD;
                r_streak <= '0;
            end
            if (w_done) begin
                r_mReq <= 1'b0;
                if (r_owner == OWN_I) begin
                    r_iReady <= 1'b1;
                    r_iRdata <= w_respData;
                    r_iErr   <= w_respErr;
                end else begin
                    r_dReady <= 1'b1;
                    r_dRdata <= w_respData;
                    r_dErr   <= w_respErr;
                end
            end
        end
    end

    assign m_req   = r_mReq;
    assign m_we    = r_mWe;
    assign m_addr  = r_mAddr;
    assign m_wd    = r_mWd;
    assign m_wc    = r_mWc;
    assign i_rdata = r_iRdata;
    assign i_ready = r_iReady;
    assign i_err   = r_iErr;
    assign d_rdata = r_dRdata;
    assign d_ready = r_dReady;
    assign d_err   = r_dErr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: drives and samples on the
// falling clock edge and plays the memory slave by hand.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MAX_D_STREAK = 4;
    localparam int TIMEOUT      = 64;

    logic              CLK = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wd;
    logic [1:0]        d_wc;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_err;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wd;
    logic [1:0]        m_wc;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_D_STREAK (MAX_D_STREAK),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wd    (d_wd),
        .d_wc    (d_wc),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wd    (m_wd),
        .m_wc    (m_wc),
        .m_ack   (m_ack),
        .m_rdata (m_rdata)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe, input logic [31:0] daddr,
                                 input logic [31:0] dwd, input logic [1:0] dwc);
        i_req  = ireq;
        i_addr = iaddr;
        d_req  = dreq;
        d_we   = dwe;
        d_addr = daddr;
        d_wd   = dwd;
        d_wc   = dwc;
    endtask

    task automatic waitMreq(input string tag);
        for (int n = 0; n < 20 && m_req !== 1'b1; n++) @(negedge CLK);
        checkOutput(tag, m_req, 1);
    endtask

    task automatic ackNow(input logic [31:0] data);
        m_ack   = 1'b1;
        m_rdata = data;
        @(negedge CLK);
        m_ack   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int   cnt;
        logic readySeen;

        reset   = 1'b1;
        m_ack   = 1'b0;
        m_rdata = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
        repeat (2) @(negedge CLK);
        checkOutput("reset_ctrl", {m_req, m_we, i_ready, d_ready, i_err, d_err}, 0);
        checkOutput("reset_addr", m_addr, 0);
        checkOutput("reset_rdata", {i_rdata, d_rdata}, 0);
        reset = 1'b0;
        @(negedge CLK);

        // Stray ack while idle
        m_ack   = 1'b1;
        m_rdata = 32'h77;
        @(negedge CLK);
        m_ack = 1'b0;
        @(negedge CLK);
        checkOutput("idle_ack_ignored", {m_req, i_ready, d_ready}, 0);

        // Fetch only
        applyStimulus(1, 32'h0001_0000, 0, 0, 0, 0, 2'b00);
        @(negedge CLK);
        checkOutput("t1_mreq", m_req, 1);
        checkOutput("t1_mwe", m_we, 0);
        checkOutput("t1_maddr", m_addr, 32'h0001_0000);
        checkOutput("t1_mwc", m_wc, 2'b10);
        ackNow(32'h0000_0013);
        checkOutput("t1_iready", i_ready, 1);
        checkOutput("t1_irdata", i_rdata, 32'h0000_0013);
        checkOutput("t1_ierr", i_err, 0);
        checkOutput("t1_dready", d_ready, 0);
        checkOutput("t1_mreq_drop", m_req, 0);
        i_req = 1'b0;
        @(negedge CLK);
        checkOutput("t1_iready_pulse", i_ready, 0);

        // Simultaneous requests: data write first
        applyStimulus(1, 32'h0001_0000, 1, 1, 32'h80, 32'hDEAD_BEEF, 2'b10);
        @(negedge CLK);
        checkOutput("t2_mreq", m_req, 1);
        checkOutput("t2_mwe", m_we, 1);
        checkOutput("t2_maddr", m_addr, 32'h80);
        checkOutput("t2_mwd", m_wd, 32'hDEAD_BEEF);
        checkOutput("t2_mwc", m_wc, 2'b10);
        ackNow(32'h1234_5678);
        checkOutput("t2_dready", d_ready, 1);
        checkOutput("t2_iready_first", i_ready, 0);
        checkOutput("t2_drdata_write", d_rdata, 0);
        checkOutput("t2_derr", d_err, 0);
        d_req = 1'b0;
        @(negedge CLK);
        waitMreq("t2_i_grant");
        checkOutput("t2_i_maddr", m_addr, 32'h0001_0000);
        checkOutput("t2_i_mwe", m_we, 0);
        ackNow(32'h0000_0013);
        checkOutput("t2_iready", i_ready, 1);
        checkOutput("t2_dready_second", d_ready, 0);
        i_req = 1'b0;
        @(negedge CLK);
        checkOutput("t2_streak", dut.r_streak, 0);

        // Starvation guard: four data grants then the fetch
        applyStimulus(1, 32'h0001_0000, 1, 0, 32'h400, 0, 2'b10);
        for (int g = 0; g < 5; g++) begin
            waitMreq($sformatf("t3_grant%0d", g));
            checkOutput($sformatf("t3_maddr%0d", g), m_addr, (g < 4) ? 32'h400 : 32'h0001_0000);
            checkOutput($sformatf("t3_streak%0d", g), dut.r_streak, (g < 4) ? g + 1 : 0);
            ackNow(32'h1000 + g);
            if (g < 4) begin
                checkOutput($sformatf("t3_dready%0d", g), {d_ready, i_ready}, 2'b10);
            end else begin
                checkOutput("t3_iready", {d_ready, i_ready}, 2'b01);
                checkOutput("t3_irdata", i_rdata, 32'h1004);
                applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
            end
        end
        @(negedge CLK);
        checkOutput("t3_streak_after", dut.r_streak, 0);

        // Timeout on a data read
        m_rdata = 32'hBAD0_BAD0;
        applyStimulus(0, 0, 1, 0, 32'h100, 0, 2'b10);
        waitMreq("t4_grant");
        cnt = 0;
        while (m_req === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge CLK);
        end
        checkOutput("t4_mreq_cycles", cnt, TIMEOUT);
        checkOutput("t4_dready", d_ready, 1);
        checkOutput("t4_derr", d_err, 1);
        checkOutput("t4_drdata", d_rdata, 0);
        d_req = 1'b0;
        @(negedge CLK);

        // Ack on the last wait cycle beats the timeout
        applyStimulus(0, 0, 1, 0, 32'h200, 0, 2'b10);
        waitMreq("t5_grant");
        repeat (TIMEOUT - 1) @(negedge CLK);
        checkOutput("t5_mreq_held", m_req, 1);
        ackNow(32'hCAFE_F00D);
        checkOutput("t5_dready", d_ready, 1);
        checkOutput("t5_derr", d_err, 0);
        checkOutput("t5_drdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        @(negedge CLK);

        // Reset in the middle of a fetch
        applyStimulus(1, 32'h3000, 0, 0, 0, 0, 2'b00);
        waitMreq("t6_grant");
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        i_req = 1'b0;
        #1;
        checkOutput("t6_mreq_reset", m_req, 0);
        readySeen = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            readySeen = readySeen | i_ready | m_req;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            readySeen = readySeen | i_ready | m_req;
        end
        checkOutput("t6_no_ready", readySeen, 0);
        applyStimulus(1, 32'h4000, 0, 0, 0, 0, 2'b00);
        waitMreq("t6_regrant");
        checkOutput("t6_maddr", m_addr, 32'h4000);
        ackNow(32'h55);
        checkOutput("t6_iready", i_ready, 1);
        checkOutput("t6_irdata", i_rdata, 32'h55);
        checkOutput("t6_ierr", i_err, 0);
        i_req = 1'b0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, variable-latency unified memory between the core's instruction-fetch port and its data port. Both ports use a request/ready handshake toward the core. The memory side uses a req/ack handshake. The block decides which port is granted and sequences each transaction through an FSM. It guards against instruction starvation and against a memory slave that never acks. Per-port ready signals feed the hazard logic as stall sources: a port stalls while its req is high and its ready is low.

Parameters:
- ADDR_W, 32: address width for both ports and the memory side.
- DATA_W, 32: data width.
- MAX_D_STREAK, 4: maximum consecutive data grants allowed while an instruction request is pending (1..15).
- TIMEOUT, 64: number of memory-side wait cycles before an access is aborted (2..255).

Ports:
- CLK, input, 1: clock.
- reset, input, 1: asynchronous, active-high.
- i_req, input, 1: fetch request; level signal, held until i_ready.
- i_addr, input, ADDR_W: fetch address.
- i_rdata, output, DATA_W: fetch read data; valid while i_ready=1.
- i_ready, output, 1: one-cycle completion pulse for the fetch port.
- i_err, output, 1: fetch aborted by timeout; valid with i_ready.
- d_req, input, 1: data request; level signal, held until d_ready.
- d_we, input, 1: 1 = write, 0 = read.
- d_addr, input, ADDR_W: data address.
- d_wd, input, DATA_W: write data.
- d_wc, input, 2: write control (00 byte, 01 half, 10 word).
- d_rdata, output, DATA_W: data read result; valid while d_ready=1.
- d_ready, output, 1: one-cycle completion pulse for the data port.
- d_err, output, 1: data access aborted by timeout; valid with d_ready.
- m_req, output, 1: memory request; held until m_ack or timeout.
- m_we, output, 1: memory write enable.
- m_addr, output, ADDR_W: memory address.
- m_wd, output, DATA_W: memory write data.
- m_wc, output, 2: memory write control.
- m_ack, input, 1: memory completion; asserted for one cycle.
- m_rdata, input, DATA_W: memory read data; valid with m_ack.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, streak counter 0, timer 0. Reset asserted mid-transaction drops m_req at once and discards the transaction. No ready pulse is produced for it.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE arbitration, evaluated each cycle:
  - d_req only: go to BUSY_D.
  - i_req only: go to BUSY_I.
  - Both requesting: data wins unless streak == MAX_D_STREAK, in which case instruction wins.
  - Neither requesting: stay in IDLE.
- Grant register:
  - On the IDLE-exit edge, latch addr/we/wd/wc into the m_* registers and assert m_req.
  - Instruction grants always drive m_we=0 and m_wc=10.
  - m_* outputs are registered and stay stable for the whole BUSY state.
- Streak counter:
  - Increments on a data grant made while i_req=1, saturating at MAX_D_STREAK.
  - Clears on any instruction grant, and on a data grant made while i_req=0.
- BUSY_x:
  - Timer counts up from 0 each cycle while m_ack=0.
  - On m_ack=1: latch m_rdata (0 for writes), set err=0, drop m_req, go to RESP.
  - On the cycle the timer reaches TIMEOUT-1 with m_ack=0: drop m_req, latch rdata=0, set err=1, go to RESP.
  - m_ack and timeout in the same cycle: ack wins, err=0.
- RESP: pulse the granted port's ready for exactly one cycle, with its rdata/err registered. Then go to IDLE. The other port's ready stays 0.
- Latency: a req sampled in IDLE at cycle 0 gives m_req at cycle 1. m_ack at cycle k (k ≥ 1) gives ready at cycle k+1. Minimum turnaround is 2 cycles. IDLE re-arbitrates the cycle after RESP.
- Requester rules:
  - Requesters keep address and data stable from req until ready.
  - A requester keeping req high in the ready cycle is not seen as a new request until IDLE.
  - Dropping req while granted does not abort the transaction; the ready pulse still fires.
- m_ack arriving in IDLE or RESP is ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum (IDLE, BUSY_I, BUSY_D, RESP).
  - arb_owner_t enum (OWN_I, OWN_D).
  - WC_BYTE/WC_HALF/WC_WORD constants, shared with the memory stage's write-control encoding.
- One sub-module, mem_arb_timer: a loadable wait counter with clear, enable and expired output, parameterised by TIMEOUT.

Test Plan:
1. Fetch only: i_req=1, i_addr=0x00010000, m_ack one cycle after m_req with m_rdata=0x00000013 → m_req high 1 cycle with m_we=0; i_ready pulses 1 cycle later with i_rdata=0x00000013, i_err=0.
2. Simultaneous: i_req=d_req=1, d_we=1, d_addr=0x80, d_wd=0xDEADBEEF, d_wc=10 → data granted first with m_wd=0xDEADBEEF and m_wc=10; d_ready precedes i_ready.
3. Starvation guard: i_req held 1 while d_req is reasserted each time IDLE is reached, MAX_D_STREAK=4 → exactly 4 data grants, then 1 instruction grant; streak reads 0 afterwards.
4. Timeout: d_req=1 read, m_ack never asserted, TIMEOUT=64 → m_req drops after 64 cycles; d_ready=1, d_err=1, d_rdata=0.
5. Ack on the timeout cycle: m_ack at wait cycle 63 → d_err=0 and d_rdata equals m_rdata.
6. Reset mid-BUSY_I: assert reset 3 cycles into the wait → m_req=0, i_ready never pulses; after release, a new i_req completes normally.
